mult_div_unit: RTL and testbench

Multi-cycle signed 32-bit multiply/divide unit that consumes the `multOp`/`divOp` requests produced by the ALU control decoder. It writes the HI/LO registers that the `StoreMD` path later selects for the register file. The main control FSM holds its control type steady and waits on `done` before advancing.

---
 rtl/mult_div_pkg.sv | 20 ++
 rtl/mult_div_if.sv | 26 ++
 rtl/mult_div_div_step.sv | 24 ++
 rtl/mult_div_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multi-cycle signed multiply/divide unit.
// Holds the FSM state encoding, the operand/iteration widths and the
// 64-bit accumulator type used for full-width products.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE,
        HOLD
    } state_t;

    typedef logic signed [2*MD_WIDTH-1:0] acc_t;

endpackage

// File: rtl/mult_div_if.sv
// Request/result bundle between the main control FSM (master) and the
// multiply/divide unit (slave).
interface mult_div_if;
    import mult_div_pkg::*;

    logic                multOp;
    logic                divOp;
    logic [MD_WIDTH-1:0] a;
    logic [MD_WIDTH-1:0] b;
    logic [MD_WIDTH-1:0] hi;
    logic [MD_WIDTH-1:0] lo;
    logic                busy;
    logic                done;
    logic                div_zero;

    modport master (
        output multOp, divOp, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  multOp, divOp, a, b,
        output hi, lo, busy, done, div_zero
    );

endinterface

// File: rtl/mult_div_div_step.sv
// One combinational restoring-division step on unsigned magnitudes:
// shift the next dividend bit into the partial remainder and subtract the
// divisor when it fits.
module div_step
    import mult_div_pkg::*;
(
    input  logic [MD_WIDTH-1:0] rem_i,
    input  logic [MD_WIDTH-1:0] divisor_i,
    input  logic                bit_i,
    output logic [MD_WIDTH-1:0] rem_o,
    output logic                qBit_o
);

    logic [MD_WIDTH:0] shifted;

    // Trial subtraction; the remainder always stays below the divisor, so a
    // modulo-2^32 difference is exact whenever the subtraction is taken.
    always_comb begin
        shifted = {rem_i, bit_i};
        qBit_o  = (shifted >= {1'b0, divisor_i});
        rem_o   = qBit_o ? (shifted[MD_WIDTH-1:0] - divisor_i) : shifted[MD_WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed 32-bit multiply/divide unit writing the HI/LO pair.
// Multiply is radix-2 Booth (one step per cycle); divide is restoring
// division on magnitudes with sign fix-up in the FIX state.
// Optional feature macro: MULTDIV_FAST_MULT_EN selects a single-cycle
// combinational 32x32 product instead of the Booth sequence.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int ITER = MD_ITER
) (
    input  logic      clk,
    input  logic      reset_n,
    mult_div_if.slave bus
);

    localparam int CNT_W = $clog2(ITER);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MD_WIDTH-1:0] accHi_q, accHi_d;
    logic [MD_WIDTH-1:0] accLo_q, accLo_d;
    logic [MD_WIDTH-1:0] mcand_q, mcand_d;
    logic [MD_WIDTH-1:0] hi_q, hi_d;
    logic [MD_WIDTH-1:0] lo_q, lo_d;
    logic                isDiv_q, isDiv_d;
    logic                aNeg_q, aNeg_d;
    logic                bNeg_q, bNeg_d;
    logic                bZero_q, bZero_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                divZero_q, divZero_d;

    logic [MD_WIDTH-1:0] stepRem;
    logic                stepQ;
    acc_t                multResult;

    div_step uDivStep (
        .rem_i     (accHi_q),
        .divisor_i (mcand_q),
        .bit_i     (accLo_q[MD_WIDTH-1]),
        .rem_o     (stepRem),
        .qBit_o    (stepQ)
    );

`ifdef MULTDIV_FAST_MULT_EN
    acc_t fastProd;

    // Full signed product from the latched operands in a single cycle.
    always_comb begin
        fastProd = acc_t'($signed(mcand_q)) * acc_t'($signed(accLo_q));
    end
`else
    logic                boothBit_q, boothBit_d;
    logic [MD_WIDTH:0]   boothSum;
    logic [MD_WIDTH-1:0] boothHi;
    logic [MD_WIDTH-1:0] boothLo;

    // One Booth step: add/subtract the multiplicand on the upper half with a
    // guard bit, then arithmetic-shift {hi, lo, booth bit} right by one.
    always_comb begin
        case ({accLo_q[0], boothBit_q})
            2'b01:   boothSum = {accHi_q[MD_WIDTH-1], accHi_q} + {mcand_q[MD_WIDTH-1], mcand_q};
            2'b10:   boothSum = {accHi_q[MD_WIDTH-1], accHi_q} - {mcand_q[MD_WIDTH-1], mcand_q};
            default: boothSum = {accHi_q[MD_WIDTH-1], accHi_q};
        endcase
        boothHi = boothSum[MD_WIDTH:1];
        boothLo = {boothSum[0], accLo_q[MD_WIDTH-1:1]};
    end
`endif

    // View the working pair as one 64-bit product for the multiply write-back.
    always_comb begin
        multResult = {accHi_q, accLo_q};
    end

    // Next-state and datapath updates; every register holds unless its state says otherwise.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accHi_d   = accHi_q;
        accLo_d   = accLo_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        isDiv_d   = isDiv_q;
        aNeg_d    = aNeg_q;
        bNeg_d    = bNeg_q;
        bZero_d   = bZero_q;
        divZero_d = divZero_q;
`ifndef MULTDIV_FAST_MULT_EN
        boothBit_d = boothBit_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.multOp) begin
                    mcand_d   = bus.a;
                    accLo_d   = bus.b;
                    accHi_d   = '0;
                    cnt_d     = '0;
                    isDiv_d   = 1'b0;
                    divZero_d = 1'b0;
`ifndef MULTDIV_FAST_MULT_EN
                    boothBit_d = 1'b0;
`endif
                    state_d   = MULT;
                end else if (bus.divOp) begin
                    mcand_d   = bus.b[MD_WIDTH-1] ? -bus.b : bus.b;
                    accLo_d   = bus.a[MD_WIDTH-1] ? -bus.a : bus.a;
                    accHi_d   = '0;
                    cnt_d     = '0;
                    aNeg_d    = bus.a[MD_WIDTH-1];
                    bNeg_d    = bus.b[MD_WIDTH-1];
                    bZero_d   = (bus.b == '0);
                    isDiv_d   = 1'b1;
                    divZero_d = 1'b0;
                    state_d   = DIV;
                end
            end
            MULT: begin
`ifdef MULTDIV_FAST_MULT_EN
                accHi_d = fastProd[2*MD_WIDTH-1:MD_WIDTH];
                accLo_d = fastProd[MD_WIDTH-1:0];
                state_d = FIX;
`else
                accHi_d    = boothHi;
                accLo_d    = boothLo;
                boothBit_d = accLo_q[0];
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = FIX;
                end
`endif
            end
            DIV: begin
                if (bZero_q) begin
                    divZero_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    accHi_d = stepRem;
                    accLo_d = {accLo_q[MD_WIDTH-2:0], stepQ};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (isDiv_q) begin
                    lo_d = (aNeg_q ^ bNeg_q) ? -accLo_q : accLo_q;
                    hi_d = aNeg_q ? -accHi_q : accHi_q;
                end else begin
                    hi_d = multResult[2*MD_WIDTH-1:MD_WIDTH];
                    lo_d = multResult[MD_WIDTH-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = (bus.multOp || bus.divOp) ? HOLD : IDLE;
            end
            HOLD: begin
                if (!bus.multOp && !bus.divOp) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == MULT) || (state_d == DIV) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            isDiv_q   <= 1'b0;
            aNeg_q    <= 1'b0;
            bNeg_q    <= 1'b0;
            bZero_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
`ifndef MULTDIV_FAST_MULT_EN
            boothBit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            accHi_q   <= accHi_d;
            accLo_q   <= accLo_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            isDiv_q   <= isDiv_d;
            aNeg_q    <= aNeg_d;
            bNeg_q    <= bNeg_d;
            bZero_q   <= bZero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divZero_q <= divZero_d;
`ifndef MULTDIV_FAST_MULT_EN
            boothBit_q <= boothBit_d;
`endif
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = divZero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a scoreboard queue receives the
// expected HI/LO/div_zero/latency whenever a request is driven and is
// drained when the unit signals done.
module tb_mult_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          busyCycles;
    } exp_t;

`ifdef MULTDIV_FAST_MULT_EN
    localparam int MULT_LAT  = 3;
    localparam int MULT_BUSY = 2;
`else
    localparam int MULT_LAT  = 34;
    localparam int MULT_BUSY = 33;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    mult_div_if bus ();

    mult_div_unit #(.ITER(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t        expQ[$];
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;
    int          checks  = 0;
    int          passes  = 0;

    // Drive a request (at a negedge, unit idle) and queue its expected outcome.
    task automatic sendOp(input logic doMult, input logic doDiv, input logic [31:0] opA, input logic [31:0] opB);
        exp_t   e;
        longint pa, pb, res, rem;
        bus.multOp = doMult;
        bus.divOp  = doDiv;
        bus.a      = opA;
        bus.b      = opB;
        pa   = longint'($signed(opA));
        pb   = longint'($signed(opB));
        e.dz = 1'b0;
        if (doMult) begin
            res          = pa * pb;
            e.hi         = res[63:32];
            e.lo         = res[31:0];
            e.lat        = MULT_LAT;
            e.busyCycles = MULT_BUSY;
        end else if (opB == 32'd0) begin
            e.hi         = modelHi;
            e.lo         = modelLo;
            e.dz         = 1'b1;
            e.lat        = 2;
            e.busyCycles = 1;
        end else begin
            res          = pa / pb;
            rem          = pa % pb;
            e.hi         = rem[31:0];
            e.lo         = res[31:0];
            e.lat        = 34;
            e.busyCycles = 33;
        end
        modelHi = e.hi;
        modelLo = e.lo;
        expQ.push_back(e);
    endtask

    // Wait (bounded) for done; report cycles since the request and busy cycles seen.
    task automatic waitDone(output int lat, output int busyCycles);
        lat        = -1;
        busyCycles = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busyCycles++;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.multOp = 1'b0;
        bus.divOp  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.hi !== 32'd0) $display("[TB] FAIL reset hi: got %h want 0", bus.hi); else passes++;
        checks++; if (bus.lo !== 32'd0) $display("[TB] FAIL reset lo: got %h want 0", bus.lo); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset busy: got %b want 0", bus.busy); else passes++;
        checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset done: got %b want 0", bus.done); else passes++;
        checks++; if (bus.div_zero !== 1'b0) $display("[TB] FAIL reset div_zero: got %b want 0", bus.div_zero); else passes++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multiply();
        logic [31:0] tA [3] = '{32'd7, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] tB [3] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0001};
        logic        both [3] = '{1'b0, 1'b1, 1'b0};
        int          lat, busyCycles;
        exp_t        e;
        for (int i = 0; i < 3; i++) begin
            sendOp(1'b1, both[i], tA[i], tB[i]);
            waitDone(lat, busyCycles);
            e = expQ.pop_front();
            checks++; if (lat !== e.lat) $display("[TB] FAIL mult[%0d] latency: got %0d want %0d", i, lat, e.lat); else passes++;
            checks++; if (busyCycles !== e.busyCycles) $display("[TB] FAIL mult[%0d] busy cycles: got %0d want %0d", i, busyCycles, e.busyCycles); else passes++;
            checks++; if (bus.hi !== e.hi) $display("[TB] FAIL mult[%0d] hi: got %h want %h", i, bus.hi, e.hi); else passes++;
            checks++; if (bus.lo !== e.lo) $display("[TB] FAIL mult[%0d] lo: got %h want %h", i, bus.lo, e.lo); else passes++;
            checks++; if (bus.div_zero !== e.dz) $display("[TB] FAIL mult[%0d] div_zero: got %b want %b", i, bus.div_zero, e.dz); else passes++;
            bus.multOp = 1'b0;
            bus.divOp  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_divide();
        logic [31:0] tA [5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FF9C, 32'd5};
        logic [31:0] tB [5] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd9};
        int          lat, busyCycles;
        exp_t        e;
        for (int i = 0; i < 5; i++) begin
            sendOp(1'b0, 1'b1, tA[i], tB[i]);
            waitDone(lat, busyCycles);
            e = expQ.pop_front();
            checks++; if (lat !== e.lat) $display("[TB] FAIL div[%0d] latency: got %0d want %0d", i, lat, e.lat); else passes++;
            checks++; if (busyCycles !== e.busyCycles) $display("[TB] FAIL div[%0d] busy cycles: got %0d want %0d", i, busyCycles, e.busyCycles); else passes++;
            checks++; if (bus.hi !== e.hi) $display("[TB] FAIL div[%0d] hi: got %h want %h", i, bus.hi, e.hi); else passes++;
            checks++; if (bus.lo !== e.lo) $display("[TB] FAIL div[%0d] lo: got %h want %h", i, bus.lo, e.lo); else passes++;
            checks++; if (bus.div_zero !== e.dz) $display("[TB] FAIL div[%0d] div_zero: got %b want %b", i, bus.div_zero, e.dz); else passes++;
            bus.divOp = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] tA [3]  = '{32'h451, 32'h1234, 32'd3};
        logic [31:0] tB [3]  = '{32'h20, 32'd0, 32'd4};
        logic        isM [3] = '{1'b0, 1'b0, 1'b1};
        int          lat, busyCycles;
        exp_t        e;
        for (int i = 0; i < 3; i++) begin
            sendOp(isM[i], ~isM[i], tA[i], tB[i]);
            waitDone(lat, busyCycles);
            e = expQ.pop_front();
            checks++; if (lat !== e.lat) $display("[TB] FAIL dz[%0d] latency: got %0d want %0d", i, lat, e.lat); else passes++;
            checks++; if (busyCycles !== e.busyCycles) $display("[TB] FAIL dz[%0d] busy cycles: got %0d want %0d", i, busyCycles, e.busyCycles); else passes++;
            checks++; if (bus.hi !== e.hi) $display("[TB] FAIL dz[%0d] hi: got %h want %h", i, bus.hi, e.hi); else passes++;
            checks++; if (bus.lo !== e.lo) $display("[TB] FAIL dz[%0d] lo: got %h want %h", i, bus.lo, e.lo); else passes++;
            checks++; if (bus.div_zero !== e.dz) $display("[TB] FAIL dz[%0d] div_zero: got %b want %b", i, bus.div_zero, e.dz); else passes++;
            if (i == 1) begin
                checks++; if ({bus.hi, bus.lo} !== {32'h11, 32'h22}) $display("[TB] FAIL dz kept hi/lo: got %h/%h want 11/22", bus.hi, bus.lo); else passes++;
            end
            bus.multOp = 1'b0;
            bus.divOp  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        int   doneCount = 0;
        int   firstDone = -1;
        int   lat, busyCycles;
        exp_t e;
        sendOp(1'b1, 1'b0, 32'h0001_2345, 32'hFFFF_FFF0);
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                doneCount++;
                if (firstDone < 0) firstDone = i;
            end
        end
        e = expQ.pop_front();
        checks++; if (doneCount !== 1) $display("[TB] FAIL hold done pulses: got %0d want 1", doneCount); else passes++;
        checks++; if (firstDone !== e.lat) $display("[TB] FAIL hold latency: got %0d want %0d", firstDone, e.lat); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL hold restarted busy: got %b want 0", bus.busy); else passes++;
        checks++; if (bus.hi !== e.hi) $display("[TB] FAIL hold hi: got %h want %h", bus.hi, e.hi); else passes++;
        checks++; if (bus.lo !== e.lo) $display("[TB] FAIL hold lo: got %h want %h", bus.lo, e.lo); else passes++;
        bus.multOp = 1'b0;
        @(negedge clk);
        sendOp(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(lat, busyCycles);
        e = expQ.pop_front();
        checks++; if (lat !== e.lat) $display("[TB] FAIL rearm latency: got %0d want %0d", lat, e.lat); else passes++;
        checks++; if (bus.hi !== e.hi) $display("[TB] FAIL rearm hi: got %h want %h", bus.hi, e.hi); else passes++;
        checks++; if (bus.lo !== e.lo) $display("[TB] FAIL rearm lo: got %h want %h", bus.lo, e.lo); else passes++;
        bus.multOp = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int   lat, busyCycles;
        exp_t e;
        sendOp(1'b0, 1'b1, 32'hFFFF_0001, 32'd3);
        repeat (10) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL abort busy before reset: got %b want 1", bus.busy); else passes++;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.hi !== 32'd0) $display("[TB] FAIL abort hi: got %h want 0", bus.hi); else passes++;
        checks++; if (bus.lo !== 32'd0) $display("[TB] FAIL abort lo: got %h want 0", bus.lo); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL abort busy: got %b want 0", bus.busy); else passes++;
        checks++; if (bus.done !== 1'b0) $display("[TB] FAIL abort done: got %b want 0", bus.done); else passes++;
        checks++; if (bus.div_zero !== 1'b0) $display("[TB] FAIL abort div_zero: got %b want 0", bus.div_zero); else passes++;
        void'(expQ.pop_back());
        modelHi = '0;
        modelLo = '0;
        @(negedge clk);
        sendOp(1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FF00);
        reset_n = 1'b1;
        waitDone(lat, busyCycles);
        e = expQ.pop_front();
        checks++; if (lat !== e.lat) $display("[TB] FAIL post-reset latency: got %0d want %0d", lat, e.lat); else passes++;
        checks++; if (bus.hi !== e.hi) $display("[TB] FAIL post-reset hi: got %h want %h", bus.hi, e.hi); else passes++;
        checks++; if (bus.lo !== e.lo) $display("[TB] FAIL post-reset lo: got %h want %h", bus.lo, e.lo); else passes++;
        bus.divOp = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random_ops();
        logic        isM;
        logic [31:0] opA, opB;
        int          lat, busyCycles;
        exp_t        e;
        for (int i = 0; i < 8; i++) begin
            isM = 1'($urandom_range(0, 1));
            opA = $urandom;
            opB = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i % 4 == 1) opB = -opB;
            if (!isM && opB == 32'd0) opB = 32'd1;
            sendOp(isM, ~isM, opA, opB);
            waitDone(lat, busyCycles);
            e = expQ.pop_front();
            checks++; if (lat !== e.lat) $display("[TB] FAIL rnd[%0d] latency: got %0d want %0d", i, lat, e.lat); else passes++;
            checks++; if (bus.hi !== e.hi) $display("[TB] FAIL rnd[%0d] hi (a=%h b=%h): got %h want %h", i, opA, opB, bus.hi, e.hi); else passes++;
            checks++; if (bus.lo !== e.lo) $display("[TB] FAIL rnd[%0d] lo (a=%h b=%h): got %h want %h", i, opA, opB, bus.lo, e.lo); else passes++;
            bus.multOp = 1'b0;
            bus.divOp  = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_zero();
        test_hold();
        test_reset_abort();
        test_random_ops();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
